// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the memory bus arbiter between instruction fetch and the MEM stage.
package mem_arbiter_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2
  } arb_state_e;

  // Watchdog counter width: 8 bits covers the usual timeouts, 16 bits the rest.
  function automatic int wd_width(input int unsigned timeout);
    return (timeout > 255) ? 16 : 8;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory bus between fetch and the MEM stage, one
// req/ack transaction at a time, with stall requests and an ack watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [REG_W-1:0]  if_rdata,
  output logic              if_done,
  output logic              if_stall_req,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [BE_W-1:0]   mem_be,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [REG_W-1:0]  mem_wdata,
  output logic [REG_W-1:0]  mem_rdata,
  output logic              mem_done,
  output logic              mem_stall_req,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BE_W-1:0]   bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [REG_W-1:0]  bus_wdata,
  input  logic              bus_ack,
  input  logic [REG_W-1:0]  bus_rdata,
  output logic              bus_err,
  output arb_state_e        dbg_state_o
);

  localparam int WD_W = wd_width(TIMEOUT);

  arb_state_e        state_q;
  logic              bus_req_q, bus_we_q, bus_err_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [REG_W-1:0]  bus_wdata_q;
  logic              if_done_q, mem_done_q, cancel_q;
  logic [REG_W-1:0]  if_rdata_q, mem_rdata_q;

  logic mem_elig, if_elig, busy, wd_expire, if_drop;

  // A requester whose done is high is still showing the request it just finished.
  assign mem_elig = mem_req & ~mem_done_q;
  assign if_elig  = if_req & ~if_done_q;
  assign busy     = (state_q != ARB_IDLE);
  assign if_drop  = cancel_q | if_flush;

  generate
    if (TIMEOUT != 0) begin : g_wd
      logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
      // Busy cycle k sees count k; the grant cycle preloads 1.
      always_comb begin
        wd_cnt_d = (state_q == ARB_IDLE) ? WD_W'(1) : wd_cnt_q + WD_W'(1);
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt_q <= '0;
        else        wd_cnt_q <= wd_cnt_d;
      end
      assign wd_expire = busy && (wd_cnt_q == WD_W'(TIMEOUT));
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      cancel_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          cancel_q <= 1'b0;
          if (mem_elig) begin
            state_q     <= ARB_MEM_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_be_q    <= mem_be;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
          end else if (if_elig) begin
            state_q     <= ARB_IF_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'hF;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
          end
        end
        ARB_IF_BUSY: begin
          if (bus_ack || wd_expire) begin
            state_q   <= ARB_IDLE;
            bus_req_q <= 1'b0;
            cancel_q  <= 1'b0;
            if (!bus_ack) bus_err_q <= 1'b1;
            // A flushed fetch still finishes on the bus but is invisible to the pipeline.
            if (!if_drop) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus_ack ? bus_rdata : '0;
            end
          end else if (if_flush) begin
            cancel_q <= 1'b1;
          end
        end
        ARB_MEM_BUSY: begin
          if (bus_ack || wd_expire) begin
            state_q     <= ARB_IDLE;
            bus_req_q   <= 1'b0;
            mem_done_q  <= 1'b1;
            mem_rdata_q <= bus_ack ? bus_rdata : '0;
            if (!bus_ack) bus_err_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata      = if_rdata_q;
  assign if_done       = if_done_q;
  assign if_stall_req  = if_req & ~if_done_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_done      = mem_done_q;
  assign mem_stall_req = mem_req & ~mem_done_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_be        = bus_be_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_err       = bus_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, stalls, flush cancel, watchdog and async reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done, if_stall_req;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [3:0]  mem_be = 4'hF;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_stall_req;
  logic        bus_req, bus_we, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  arb_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall_req(if_stall_req),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_stall_req(mem_stall_req),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_state", dbg_state, ARB_IDLE);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    #9 rst_n = 1'b1;

    // 1: load, ack in the third busy cycle
    mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h100;
    #1 chk("t1_stall_pre", mem_stall_req, 1);
    tick();
    chk("t1_state", dbg_state, ARB_MEM_BUSY);
    chk("t1_bus_req", bus_req, 1);
    chk("t1_addr_c1", bus_addr, 32'h100);
    chk("t1_we", bus_we, 0);
    mem_addr = 32'h200;
    tick();
    chk("t1_addr_c2", bus_addr, 32'h100);
    tick();
    chk("t1_addr_c3", bus_addr, 32'h100);
    chk("t1_no_done", mem_done, 0);
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ack = 0; bus_rdata = '0;
    chk("t1_done", mem_done, 1);
    chk("t1_rdata", mem_rdata, 32'hDEADBEEF);
    chk("t1_bus_req_off", bus_req, 0);
    chk("t1_stall_done", mem_stall_req, 0);
    tick();
    chk("t1_stale_masked", dbg_state, ARB_IDLE);
    chk("t1_done_pulse", mem_done, 0);
    mem_req = 0;

    // 2: simultaneous requests, MEM first then IF
    mem_req = 1; mem_addr = 32'h300; if_req = 1; if_addr = 32'h400;
    tick();
    chk("t2_mem_first", dbg_state, ARB_MEM_BUSY);
    chk("t2_addr_mem", bus_addr, 32'h300);
    chk("t2_if_stall", if_stall_req, 1);
    bus_ack = 1; bus_rdata = 32'h11111111;
    tick();
    bus_ack = 0;
    chk("t2_mem_done", mem_done, 1);
    chk("t2_mem_rdata", mem_rdata, 32'h11111111);
    chk("t2_no_overlap", bus_req, 0);
    tick();
    mem_req = 0;
    chk("t2_if_grant", dbg_state, ARB_IF_BUSY);
    chk("t2_addr_if", bus_addr, 32'h400);
    chk("t2_if_be", bus_be, 4'hF);
    bus_ack = 1; bus_rdata = 32'h22222222;
    tick();
    bus_ack = 0;
    chk("t2_if_done", if_done, 1);
    chk("t2_if_rdata", if_rdata, 32'h22222222);
    chk("t2_mem_rdata_kept", mem_rdata, 32'h11111111);
    if_req = 0;
    tick();
    chk("t2_idle", dbg_state, ARB_IDLE);

    // bus_ack while idle is ignored
    bus_ack = 1; bus_rdata = 32'hBADBAD00;
    tick();
    bus_ack = 0;
    chk("idle_ack_state", dbg_state, ARB_IDLE);
    chk("idle_ack_done", mem_done, 0);
    chk("idle_ack_rdata", mem_rdata, 32'h11111111);

    // 3: store, fetch arrives mid-store
    mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h500; mem_wdata = 32'h1234;
    tick();
    chk("t3_we", bus_we, 1);
    chk("t3_be", bus_be, 4'b0011);
    chk("t3_wdata", bus_wdata, 32'h1234);
    if_req = 1; if_addr = 32'h600; mem_wdata = 32'hFFFF; mem_be = 4'hF;
    tick();
    chk("t3_wdata_hold", bus_wdata, 32'h1234);
    chk("t3_be_hold", bus_be, 4'b0011);
    chk("t3_still_mem", dbg_state, ARB_MEM_BUSY);
    bus_ack = 1; bus_rdata = 32'h0;
    tick();
    bus_ack = 0;
    chk("t3_mem_done", mem_done, 1);
    chk("t3_if_waits", dbg_state, ARB_IDLE);
    tick();
    mem_req = 0; mem_we = 0;
    chk("t3_if_grant", dbg_state, ARB_IF_BUSY);
    chk("t3_if_we", bus_we, 0);
    chk("t3_if_addr", bus_addr, 32'h600);
    bus_ack = 1; bus_rdata = 32'h33333333;
    tick();
    bus_ack = 0;
    chk("t3_if_rdata", if_rdata, 32'h33333333);
    if_req = 0;
    tick();

    // 4: flush one cycle after an IF grant
    if_req = 1; if_addr = 32'h700;
    tick();
    chk("t4_grant", dbg_state, ARB_IF_BUSY);
    if_flush = 1;
    tick();
    if_flush = 0;
    bus_ack = 1; bus_rdata = 32'h44444444;
    tick();
    bus_ack = 0;
    chk("t4_no_done", if_done, 0);
    chk("t4_rdata_kept", if_rdata, 32'h33333333);
    chk("t4_idle", dbg_state, ARB_IDLE);
    if_addr = 32'h800;
    tick();
    chk("t4_regrant", dbg_state, ARB_IF_BUSY);
    chk("t4_regrant_addr", bus_addr, 32'h800);
    bus_ack = 1; bus_rdata = 32'h55555555;
    tick();
    bus_ack = 0;
    chk("t4_done", if_done, 1);
    chk("t4_rdata", if_rdata, 32'h55555555);
    if_req = 0;
    tick();

    // 5a: ack in the 4th busy cycle wins over the watchdog
    mem_req = 1; mem_addr = 32'hA00;
    tick(); tick(); tick(); tick();
    chk("t5a_busy4", bus_req, 1);
    bus_ack = 1; bus_rdata = 32'h66666666;
    tick();
    bus_ack = 0;
    chk("t5a_done", mem_done, 1);
    chk("t5a_rdata", mem_rdata, 32'h66666666);
    chk("t5a_no_err", bus_err, 0);
    tick();
    mem_req = 0;

    // 5b: no ack, watchdog expires
    mem_req = 1; mem_addr = 32'h900;
    tick(); tick(); tick(); tick();
    chk("t5b_busy4", bus_req, 1);
    chk("t5b_busy4_err", bus_err, 0);
    tick();
    chk("t5b_drop", bus_req, 0);
    chk("t5b_done", mem_done, 1);
    chk("t5b_rdata0", mem_rdata, 0);
    chk("t5b_err", bus_err, 1);
    chk("t5b_idle", dbg_state, ARB_IDLE);
    tick();
    mem_req = 0;
    chk("t5b_sticky", bus_err, 1);

    // 6: reset in the middle of a MEM transaction
    mem_req = 1; mem_addr = 32'hB00;
    tick(); tick();
    chk("t6_busy", bus_req, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_bus_req", bus_req, 0);
    chk("t6_rst_done", mem_done, 0);
    chk("t6_rst_err", bus_err, 0);
    chk("t6_rst_state", dbg_state, ARB_IDLE);
    #2 rst_n = 1;
    tick();
    chk("t6_regrant", dbg_state, ARB_MEM_BUSY);
    chk("t6_regrant_addr", bus_addr, 32'hB00);
    bus_ack = 1; bus_rdata = 32'h77777777;
    tick();
    bus_ack = 0;
    chk("t6_done", mem_done, 1);
    chk("t6_rdata", mem_rdata, 32'h77777777);
    mem_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
